// File: rtl/poly_series_datapath.sv
// Iterative evaluator of y = sum_{k=0}^{TERMS-1} (k+1)*x^k, one term per clock.
// Ports: clk, rst (sync, active-high), regRst/regWrite strobes in, x_in operand,
// cntDone flag out, result (latched, saturating) out.
module poly_series_datapath #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32,
    parameter int TERMS     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 regRst,
    input  logic                 regWrite,
    input  logic [WIDTH-1:0]     x_in,
    output logic                 cntDone,
    output logic [ACC_WIDTH-1:0] result
);

    localparam logic [ACC_WIDTH-1:0] MAXV    = '1;
    localparam logic [7:0]           TERMS_C = 8'(TERMS);
    localparam logic [7:0]           LAST_C  = 8'(TERMS - 1);

    logic [WIDTH-1:0]     x_q,   x_d;
    logic [ACC_WIDTH-1:0] pow_q, pow_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] res_q, res_d;

    // Full-precision intermediates; clamp only after the exact value exists.
    logic [8:0]               cnt1;
    logic [ACC_WIDTH+8:0]     term_full;
    logic [ACC_WIDTH-1:0]     term_sat;
    logic [ACC_WIDTH+WIDTH-1:0] pow_full;
    logic [ACC_WIDTH-1:0]     pow_sat;
    logic [ACC_WIDTH:0]       sum_full;
    logic [ACC_WIDTH-1:0]     acc_sat;

    always_comb begin
        cnt1      = {1'b0, cnt_q} + 9'd1;
        term_full = {{ACC_WIDTH{1'b0}}, cnt1} * {9'd0, pow_q};
        term_sat  = (|term_full[ACC_WIDTH+8:ACC_WIDTH])
                    ? MAXV : term_full[ACC_WIDTH-1:0];
        pow_full  = {{WIDTH{1'b0}}, pow_q} * {{ACC_WIDTH{1'b0}}, x_q};
        pow_sat   = (|pow_full[ACC_WIDTH+WIDTH-1:ACC_WIDTH])
                    ? MAXV : pow_full[ACC_WIDTH-1:0];
        sum_full  = {1'b0, acc_q} + {1'b0, term_sat};
        acc_sat   = sum_full[ACC_WIDTH] ? MAXV : sum_full[ACC_WIDTH-1:0];
    end

    always_comb begin
        x_d   = x_q;
        pow_d = pow_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        res_d = res_q;
        if (regRst) begin
            x_d   = x_in;
            pow_d = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
            acc_d = '0;
            cnt_d = '0;
        end else if (regWrite) begin
            if (cnt_q < TERMS_C) begin
                acc_d = acc_sat;
                pow_d = pow_sat;
                cnt_d = cnt_q + 8'd1;
            end else begin
                // Iteration complete: publish; repeated writes re-latch.
                res_d = acc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            pow_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else begin
            x_q   <= x_d;
            pow_q <= pow_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
        end
    end

    assign cntDone = (cnt_q == LAST_C);
    assign result  = res_q;

endmodule
